// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: arbitration mode, port id and
// the read-return tag carried alongside each downstream read.
package sram_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rd_tag_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    function automatic port_id_t other_port(input port_id_t p);
        return port_id_t'(~p);
    endfunction

endpackage

// File: rtl/sram_arb_rdtag_pipe.sv
// Fixed-depth shift pipe of read tags; its head lines up with the controller's
// read-data-valid exactly RD_LAT cycles after the read was issued.
module sram_arb_rdtag_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    input  rd_tag_t push_tag,
    output rd_tag_t head_tag
);

    rd_tag_t [RD_LAT-1:0] stage_reg;
    rd_tag_t [RD_LAT-1:0] stage_next;

    genvar gi;
    generate
        for (gi = 0; gi < int'(RD_LAT); gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = push_tag;
            end else begin : g_rest
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign head_tag = stage_reg[RD_LAT-1];

endmodule

// File: rtl/avalon_sram_arbiter.sv
// Two-master Avalon-MM arbiter in front of one SRAM controller: zero-cycle
// grant, one command per cycle, read data steered back by a tag pipe.
module avalon_sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            p0_read,
    input  logic            p0_write,
    input  logic [AW-1:0]   p0_address,
    input  logic [DW-1:0]   p0_writedata,
    input  logic [DW/8-1:0] p0_byteenable,
    output logic            p0_waitrequest,
    output logic [DW-1:0]   p0_readdata,
    output logic            p0_readdatavalid,

    input  logic            p1_read,
    input  logic            p1_write,
    input  logic [AW-1:0]   p1_address,
    input  logic [DW-1:0]   p1_writedata,
    input  logic [DW/8-1:0] p1_byteenable,
    output logic            p1_waitrequest,
    output logic [DW-1:0]   p1_readdata,
    output logic            p1_readdatavalid,

    output logic            m_read,
    output logic            m_write,
    output logic [AW-1:0]   m_address,
    output logic [DW-1:0]   m_writedata,
    output logic [DW/8-1:0] m_byteenable,
    input  logic [DW-1:0]   m_readdata,
    input  logic            m_readdatavalid
);

    localparam int        CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam arb_mode_e MODE       = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    logic          req0;
    logic          req1;
    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    port_id_t      gnt_id;
    logic          sel_read;
    logic          sel_write;
    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    port_id_t      rr_ptr_reg;
    port_id_t      rr_ptr_next;
    rd_tag_t       push_tag;
    rd_tag_t       head_tag;
    logic [1:0]    rdv_vec;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // Grant is purely combinational so an uncontended request is accepted in its first cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (MODE == ARB_RR) begin
            if (req0 && req1) begin
                gnt1 = (rr_ptr_reg == PORT1);
                gnt0 = !gnt1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end else begin
            gnt1 = req1 && (!req0 || (starve_cnt_reg == STARVE_LIM));
            gnt0 = req0 && !gnt1;
        end
        if (!reset_n) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign gnt_id  = gnt1 ? PORT1 : PORT0;

    assign p0_waitrequest = !reset_n || (req0 && !gnt0);
    assign p1_waitrequest = !reset_n || (req1 && !gnt1);

    // A command with both read and write set is treated as a write.
    always_comb begin
        sel_read     = gnt1 ? p1_read       : p0_read;
        sel_write    = gnt1 ? p1_write      : p0_write;
        m_address    = gnt1 ? p1_address    : p0_address;
        m_writedata  = gnt1 ? p1_writedata  : p0_writedata;
        m_byteenable = gnt1 ? p1_byteenable : p0_byteenable;
        m_write      = any_gnt && sel_write;
        m_read       = any_gnt && sel_read && !sel_write;
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!req1 || gnt1) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
        end
        rr_ptr_next = any_gnt ? other_port(gnt_id) : rr_ptr_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_reg <= '0;
            rr_ptr_reg     <= PORT0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
    end

    assign push_tag = '{valid: m_read, id: gnt_id};

    sram_arb_rdtag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rdtag_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_tag (push_tag),
        .head_tag (head_tag)
    );

    // Data fans out to both ports; only the tagged port sees valid.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            assign rdv_vec[gi] = head_tag.valid && m_readdatavalid &&
                                 (head_tag.id == port_id_t'(gi));
        end
    endgenerate

    assign p0_readdatavalid = rdv_vec[0];
    assign p1_readdatavalid = rdv_vec[1];
    assign p0_readdata      = m_readdata;
    assign p1_readdata      = m_readdata;

    a_p0_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(p0_read && p0_write));
    a_p1_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(p1_read && p1_write));
    a_tag_matches_valid: assert property (@(posedge clk) disable iff (!reset_n)
        head_tag.valid == m_readdatavalid);

endmodule

// File: tb/tb_avalon_sram_arbiter.sv
// Self-checking bench: three arbiter configurations share one stimulus stream,
// each with its own controller model; the active one is checked per phase.
module tb_avalon_sram_arbiter;

    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int NCFG = 3;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } exp_rd_t;

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [1:0]    be0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    be1;
        logic          xw0, xw1;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          p0_read = 1'b0, p0_write = 1'b0;
    logic [AW-1:0] p0_address = '0;
    logic [DW-1:0] p0_writedata = '0;
    logic [1:0]    p0_byteenable = '0;
    logic          p1_read = 1'b0, p1_write = 1'b0;
    logic [AW-1:0] p1_address = '0;
    logic [DW-1:0] p1_writedata = '0;
    logic [1:0]    p1_byteenable = '0;

    logic          p0_wait [NCFG];
    logic          p1_wait [NCFG];
    logic          p0_rdv  [NCFG];
    logic          p1_rdv  [NCFG];
    logic [DW-1:0] p0_rdata[NCFG];
    logic [DW-1:0] p1_rdata[NCFG];
    logic          m_rd    [NCFG];
    logic          m_wr    [NCFG];
    logic [AW-1:0] m_addr  [NCFG];
    logic [DW-1:0] m_wdata [NCFG];
    logic [1:0]    m_be    [NCFG];
    logic [DW-1:0] c_rdata [NCFG];
    logic          c_rdv   [NCFG];

    int            cyc = 0;
    int            cfg = 0;
    int            checks = 0;
    int            errors = 0;
    exp_rd_t       sb_q[$];
    logic [DW-1:0] shadow [1024];
    vec_t          tbl [12];

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 37) ^ 16'h1234;
    endfunction

    function automatic int lat_of(input int c);
        return (c == 2) ? 3 : 1;
    endfunction

    function automatic vec_t mkv(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic [1:0] be0,
                                 input logic r1, input logic w1, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d1, input logic [1:0] be1,
                                 input logic xw0, input logic xw1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.xw0 = xw0; v.xw1 = xw1;
        return v;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_cfg
            localparam int LAT  = (gi == 2) ? 3 : 1;
            localparam int MODE = (gi == 1) ? 1 : 0;
            logic [DW-1:0] mem   [1024];
            logic [LAT-1:0] vpipe;
            logic [DW-1:0] dpipe [LAT];

            avalon_sram_arbiter #(
                .AW(AW), .DW(DW), .RD_LAT(LAT), .ARB_MODE(MODE), .STARVE_MAX(8)
            ) u_dut (
                .clk              (clk),
                .reset_n          (reset_n),
                .p0_read          (p0_read),
                .p0_write         (p0_write),
                .p0_address       (p0_address),
                .p0_writedata     (p0_writedata),
                .p0_byteenable    (p0_byteenable),
                .p0_waitrequest   (p0_wait[gi]),
                .p0_readdata      (p0_rdata[gi]),
                .p0_readdatavalid (p0_rdv[gi]),
                .p1_read          (p1_read),
                .p1_write         (p1_write),
                .p1_address       (p1_address),
                .p1_writedata     (p1_writedata),
                .p1_byteenable    (p1_byteenable),
                .p1_waitrequest   (p1_wait[gi]),
                .p1_readdata      (p1_rdata[gi]),
                .p1_readdatavalid (p1_rdv[gi]),
                .m_read           (m_rd[gi]),
                .m_write          (m_wr[gi]),
                .m_address        (m_addr[gi]),
                .m_writedata      (m_wdata[gi]),
                .m_byteenable     (m_be[gi]),
                .m_readdata       (c_rdata[gi]),
                .m_readdatavalid  (c_rdv[gi])
            );

            initial begin
                for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
            end

            // Controller model: read data captured at issue, valid after LAT cycles.
            always @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vpipe <= '0;
                end else begin
                    for (int k = LAT - 1; k > 0; k--) begin
                        vpipe[k] <= vpipe[k-1];
                        dpipe[k] <= dpipe[k-1];
                    end
                    vpipe[0] <= m_rd[gi];
                    dpipe[0] <= mem[m_addr[gi][9:0]];
                    if (m_wr[gi]) begin
                        if (m_be[gi][0]) mem[m_addr[gi][9:0]][7:0]  <= m_wdata[gi][7:0];
                        if (m_be[gi][1]) mem[m_addr[gi][9:0]][15:8] <= m_wdata[gi][15:8];
                    end
                end
            end

            assign c_rdv[gi]   = vpipe[LAT-1];
            assign c_rdata[gi] = dpipe[LAT-1];
        end
    endgenerate

    // Return monitor: every valid must match the oldest expected read, on time.
    always @(negedge clk) begin : monitor
        exp_rd_t       e;
        logic          v0, v1;
        logic [DW-1:0] got;
        v0  = p0_rdv[cfg];
        v1  = p1_rdv[cfg];
        got = v1 ? p1_rdata[cfg] : p0_rdata[cfg];
        if (v0 || v1) begin
            checks++;
            if (v0 && v1) begin
                errors++;
                $display("FAIL rd_both cyc=%0d got valid p0=1 p1=1 exp one port", cyc);
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected cyc=%0d got port=%0d data=%h exp no return", cyc, v1, got);
            end else begin
                e = sb_q.pop_front();
                if (v1 !== e.port || got !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_return got port=%0d data=%h cyc=%0d exp port=%0d data=%h cyc=%0d",
                             v1, got, cyc, e.port, e.data, e.due);
                end else begin
                    $display("rd_return cfg=%0d port=%0d data=%h cyc=%0d", cfg, v1, got, cyc);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL rd_missing cyc=%0d got no valid exp port=%0d data=%h", cyc, e.port, e.data);
        end
    end

    task automatic apply_cycle(input vec_t v, input bit chk_all);
        logic          g0, g1, xrd, xwr;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic [1:0]    xbe;
        p0_read = v.r0; p0_write = v.w0; p0_address = v.a0; p0_writedata = v.d0; p0_byteenable = v.be0;
        p1_read = v.r1; p1_write = v.w1; p1_address = v.a1; p1_writedata = v.d1; p1_byteenable = v.be1;
        @(negedge clk);
        checks++;
        if (p0_wait[cfg] !== v.xw0 || p1_wait[cfg] !== v.xw1) begin
            errors++;
            $display("FAIL waitreq cyc=%0d cfg=%0d got=%b%b exp=%b%b", cyc, cfg,
                     p0_wait[cfg], p1_wait[cfg], v.xw0, v.xw1);
        end
        if (chk_all) begin
            for (int i = 0; i < NCFG; i++) begin
                checks++;
                if (p0_wait[i] !== v.xw0 || p1_wait[i] !== v.xw1) begin
                    errors++;
                    $display("FAIL waitreq_all inst=%0d got=%b%b exp=%b%b", i,
                             p0_wait[i], p1_wait[i], v.xw0, v.xw1);
                end
            end
        end
        g0  = (v.r0 | v.w0) & ~v.xw0;
        g1  = (v.r1 | v.w1) & ~v.xw1;
        xwr = g1 ? v.w1 : (g0 & v.w0);
        xrd = g1 ? (v.r1 & ~v.w1) : (g0 & v.r0 & ~v.w0);
        xa  = g1 ? v.a1 : v.a0;
        xd  = g1 ? v.d1 : v.d0;
        xbe = g1 ? v.be1 : v.be0;
        checks++;
        if (m_rd[cfg] !== xrd || m_wr[cfg] !== xwr ||
            ((xrd | xwr) && m_addr[cfg] !== xa) ||
            (xwr && (m_wdata[cfg] !== xd || m_be[cfg] !== xbe))) begin
            errors++;
            $display("FAIL m_cmd cyc=%0d got rd=%b wr=%b addr=%h wd=%h be=%b exp rd=%b wr=%b addr=%h wd=%h be=%b",
                     cyc, m_rd[cfg], m_wr[cfg], m_addr[cfg], m_wdata[cfg], m_be[cfg], xrd, xwr, xa, xd, xbe);
        end
        if (xrd) sb_q.push_back('{port: g1, data: shadow[xa[9:0]], due: cyc + lat_of(cfg)});
        if (xwr) begin
            if (xbe[0]) shadow[xa[9:0]][7:0]  = xd[7:0];
            if (xbe[1]) shadow[xa[9:0]][15:8] = xd[15:8];
        end
        $display("cmd cyc=%0d cfg=%0d req=%b%b grant=%b%b rd=%b wr=%b addr=%h",
                 cyc, cfg, v.r0 | v.w0, v.r1 | v.w1, g0, g1, xrd, xwr, xa);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NCFG; i++) begin
            checks++;
            if (p0_wait[i] !== 1'b1 || p1_wait[i] !== 1'b1 || m_rd[i] !== 1'b0 ||
                m_wr[i] !== 1'b0 || p0_rdv[i] !== 1'b0 || p1_rdv[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s inst=%0d got wait=%b%b cmd=%b%b rdv=%b%b exp wait=11 cmd=00 rdv=00",
                         tag, i, p0_wait[i], p1_wait[i], m_rd[i], m_wr[i], p0_rdv[i], p1_rdv[i]);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_state(tag);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(tag);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_cycle(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

        tbl[0]  = mkv(1, 0, 18'h100, 0, 2'b11,       0, 0, 0,      0,        0,     0, 0);
        tbl[1]  = mkv(0, 0, 0,       0, 0,           0, 0, 0,      0,        0,     0, 0);
        tbl[2]  = mkv(1, 0, 18'h020, 0, 2'b11,       0, 1, 18'h020, 16'hBEEF, 2'b11, 0, 1);
        tbl[3]  = mkv(0, 0, 0,       0, 0,           0, 1, 18'h020, 16'hBEEF, 2'b11, 0, 0);
        tbl[4]  = mkv(1, 0, 18'h020, 0, 2'b11,       0, 0, 0,      0,        0,     0, 0);
        tbl[5]  = mkv(0, 1, 18'h030, 16'h1234, 2'b01, 0, 0, 0,     0,        0,     0, 0);
        tbl[6]  = mkv(0, 0, 0,       0, 0,           1, 0, 18'h030, 0,       2'b11, 0, 0);
        tbl[7]  = mkv(0, 1, 18'h031, 16'hABCD, 2'b10, 1, 0, 18'h031, 0,      2'b11, 0, 1);
        tbl[8]  = mkv(1, 0, 18'h040, 0, 2'b11,       1, 0, 18'h031, 0,       2'b11, 0, 1);
        tbl[9]  = mkv(0, 0, 0,       0, 0,           1, 0, 18'h031, 0,       2'b11, 0, 0);
        tbl[10] = mkv(0, 0, 0,       0, 0,           1, 0, 18'h040, 0,       2'b11, 0, 0);
        tbl[11] = mkv(0, 0, 0,       0, 0,           0, 0, 0,      0,        0,     0, 0);

        // A request held through reset must not leak onto the controller side.
        p0_read = 1'b1;
        p1_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_init");
        p0_read = 1'b0;
        p1_write = 1'b0;
        reset_n = 1'b1;

        cfg = 0;
        foreach (tbl[i]) apply_cycle(tbl[i], 1'b0);

        // Fixed priority with starvation guard: eight p0 grants then one p1.
        for (int k = 0; k < 18; k++) begin
            apply_cycle(mkv(1, 0, 18'(18'h200 + k), 0, 2'b11, 1, 0, 18'(18'h280 + k), 0, 2'b11,
                            (k % 9) == 8, (k % 9) != 8), 1'b0);
        end
        idle(3);

        do_reset("reset_rr");
        cfg = 1;
        for (int k = 0; k < 8; k++) begin
            apply_cycle(mkv(1, 0, 18'(18'h300 + k), 0, 2'b11, 1, 0, 18'(18'h380 + k), 0, 2'b11,
                            (k % 2) == 1, (k % 2) == 0), 1'b0);
        end
        apply_cycle(mkv(0, 0, 0, 0, 0, 1, 0, 18'h388, 0, 2'b11, 0, 0), 1'b0);
        apply_cycle(mkv(1, 0, 18'h308, 0, 2'b11, 1, 0, 18'h389, 0, 2'b11, 0, 1), 1'b0);
        idle(3);

        do_reset("reset_lat3");
        cfg = 2;
        apply_cycle(mkv(1, 0, 18'h210, 0, 2'b11, 0, 0, 0,      0, 0,     0, 0), 1'b0);
        apply_cycle(mkv(0, 0, 0,      0, 0,     1, 0, 18'h290, 0, 2'b11, 0, 0), 1'b0);
        apply_cycle(mkv(1, 0, 18'h211, 0, 2'b11, 0, 0, 0,      0, 0,     0, 0), 1'b0);
        apply_cycle(mkv(1, 0, 18'h212, 0, 2'b11, 1, 0, 18'h291, 0, 2'b11, 0, 1), 1'b0);
        apply_cycle(mkv(0, 0, 0,      0, 0,     1, 0, 18'h291, 0, 2'b11, 0, 0), 1'b0);
        apply_cycle(mkv(0, 0, 0,      0, 0,     1, 0, 18'h292, 0, 2'b11, 0, 0), 1'b0);
        idle(5);

        // Reset with two reads in flight: both returns must vanish.
        apply_cycle(mkv(1, 0, 18'h220, 0, 2'b11, 0, 0, 0,      0, 0,     0, 0), 1'b0);
        apply_cycle(mkv(0, 0, 0,      0, 0,     1, 0, 18'h2A0, 0, 2'b11, 0, 0), 1'b0);
        p0_read = 1'b1;
        p0_address = 18'h230;
        p1_read = 1'b1;
        p1_address = 18'h2B0;
        do_reset("reset_inflight");
        apply_cycle(mkv(1, 0, 18'h230, 0, 2'b11, 1, 0, 18'h2B0, 0, 2'b11, 0, 1), 1'b1);
        idle(5);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d outstanding exp 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before %0d ns", 200000);
        $fatal(1, "watchdog expired");
    end

endmodule
